awg_seq_ctrl: RTL and testbench
===============================

Name: awg_seq_ctrl

Overview:
- Segment sequencer that drives the waveform generator's control inputs: `state`, `state_freq`, `state_amp` and `state_phase`.
- Holds a small table of waveform segments, written by the host or front panel. Each segment has a waveform select, frequency, amplitude, phase and dwell time.
- On `start`, plays the segments in order, each for an exact number of clock cycles. The sequence can loop.
- When idle or stopped, forces the generator to the mute state (5'd10).

Parameters:
- DEPTH, 8: number of segment table entries. Must be a power of 2, at least 2.
- DWELL_W, 16: width of the per-segment dwell count, in ticks.
- TICK_DIV, 50000: clock cycles per dwell tick. Must be at least 1.

Ports:
- clk  in  1  system clock, shared with the DAC path
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  log2(DEPTH)  table entry to write
- cfg_wave  in  5  waveform code: 0 saw, 1 tri, 2 sqr, 3 sin, 10 mute
- cfg_freq  in  12  frequency word
- cfg_amp  in  8  amplitude word
- cfg_phase  in  8  phase word
- cfg_dwell  in  DWELL_W  dwell in ticks
- cfg_len  in  log2(DEPTH)+1  number of active segments, 0..DEPTH
- loop_en  in  1  1 = wrap to segment 0 after the last segment
- start  in  1  single-cycle request to begin the sequence
- stop  in  1  single-cycle request to abort
- state  out  5  waveform select to the generator
- state_freq  out  12  frequency word to the generator
- state_amp  out  8  amplitude word to the generator
- state_phase  out  8  phase word to the generator
- busy  out  1  high while in RUN
- seg_idx  out  log2(DEPTH)  index of the segment currently playing
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: FSM goes to IDLE. Outputs: state=5'd10, state_freq=0, state_amp=0, state_phase=0, busy=0, seg_idx=0, done=0. Prescaler and dwell counter clear. The table is not cleared; its contents are undefined until written.
- Table is a register array, read combinationally by `seg_idx`. A `cfg_we` write lands at the clock edge. Writes are allowed in any state. A write to the segment currently playing does not change the latched outputs; it takes effect the next time that segment is entered.
- All control outputs are registered.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - Outputs held at the mute values.
  - `start`=1 with `cfg_len`≠0 and `stop`=0: latch segment 0 onto the outputs, set busy=1, clear the counters, go to RUN. Latency is one edge: outputs are valid in the cycle after `start` is sampled.
  - `start` with `cfg_len`=0 is ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1; a tick fires on its terminal count.
  - The dwell counter increments on each tick.
  - A dwell value of 0 is treated as 1. So segment k lasts exactly max(dwell,1)×TICK_DIV cycles.
  - At the segment's final cycle, if seg_idx<cfg_len-1: latch segment seg_idx+1 in the same edge. There are no gap cycles and no mute between segments.
  - At the final cycle of the last segment, if loop_en=1: latch segment 0 and continue.
  - At the final cycle of the last segment, if loop_en=0: go to DONE.
  - `cfg_len` and `loop_en` are sampled live, at each segment boundary.
  - If `cfg_len` drops to ≤ seg_idx, the current segment is treated as the last one.
  - `start` while in RUN is ignored; it does not restart the sequence.
- DONE: outputs mute, busy=0, done=1 for exactly one cycle, then go to IDLE.
- `stop` in any state: on the next edge go to IDLE with mute outputs and busy=0; done is not pulsed. `stop` and `start` in the same cycle: stop wins.
- `rst` mid-sequence: same effect as reset. No done pulse is produced.
- Boundary cases:
  - cfg_len=DEPTH: seg_idx wraps DEPTH-1 → 0 correctly.
  - TICK_DIV=1: each tick equals one clock cycle.
  - Waveform codes other than 0–3 and 10 are passed through unchanged; the generator outputs 0 for them.

Optional Feature:
- Macro: AWG_SEQ_REPEAT_EN.
- When defined:
  - Adds input `rep_cnt[7:0]`, latched at `start`.
  - With loop_en=0, the sequence plays rep_cnt+1 full passes before DONE.
  - Adds output `pass_idx[7:0]`: current pass number, reset to 0 at start.
  - loop_en=1 still loops forever.
- When not defined: no `rep_cnt` or `pass_idx` ports; loop_en=0 means exactly one pass.

Test Plan:
- Basic sequence, TICK_DIV=4, table {0:(wave 0, dwell 2), 1:(wave 3, dwell 1)}, cfg_len=2, loop_en=0, pulse `start` → state=0 for 8 cycles, then state=3 for 4 cycles, then done=1 for 1 cycle, then state=10 and busy=0.
- Loop, same table with loop_en=1 → segment pattern 0,1,0,1… with no mute cycles at the wrap, each segment exactly 8 or 4 cycles; `stop` at cycle 20 → state=10 one edge later, no done pulse.
- Edge cases: dwell=0 segment → lasts 4 cycles; `start` with cfg_len=0 → busy stays 0; `start` and `stop` in the same cycle → stays IDLE.
- Live table write: write segment 1 freq=0x123 while segment 0 is playing → segment 1 outputs state_freq=0x123 when entered; a write to segment 0 while it plays → the outputs do not change mid-segment.
- Reset mid-RUN with `rst`=1 → next cycle all outputs at reset values, no done pulse; a subsequent `start` replays from segment 0.
- With AWG_SEQ_REPEAT_EN defined, rep_cnt=2 and loop_en=0 → 3 passes, pass_idx counts 0,1,2, then a single done pulse.

Source files
------------

// File: rtl/awg_seq_ctrl.sv
// Segment sequencer for the waveform generator: plays a table of segments, each for an exact cycle count.
// Optional build macro AWG_SEQ_REPEAT_EN adds rep_cnt/pass_idx for a fixed number of passes.
module awg_seq_ctrl #(
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [4:0]                 cfg_wave,
  input  logic [11:0]                cfg_freq,
  input  logic [7:0]                 cfg_amp,
  input  logic [7:0]                 cfg_phase,
  input  logic [DWELL_W-1:0]         cfg_dwell,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       stop,
`ifdef AWG_SEQ_REPEAT_EN
  input  logic [7:0]                 rep_cnt,
  output logic [7:0]                 pass_idx,
`endif
  output logic [4:0]                 state,
  output logic [11:0]                state_freq,
  output logic [7:0]                 state_amp,
  output logic [7:0]                 state_phase,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   seg_idx,
  output logic                       done,
  output logic [1:0]                 fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [4:0]    WAVE_MUTE = 5'd10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} fsm_t;

  fsm_t state_q, state_n;

  // Control strobes (start, stop, cfg_we) are level-sampled on every rising edge;
  // there is no backpressure, so a one-cycle pulse is one request.
  logic [4:0]         tbl_wave  [DEPTH];
  logic [11:0]        tbl_freq  [DEPTH];
  logic [7:0]         tbl_amp   [DEPTH];
  logic [7:0]         tbl_phase [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  logic [PW-1:0]      presc_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [DWELL_W-1:0] cur_dwell_q;
  logic               tick, dwell_last, seg_end, is_last, more_pass;
  logic               load_en;
  logic [AW-1:0]      load_idx;

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_wave[cfg_addr]  <= cfg_wave;
      tbl_freq[cfg_addr]  <= cfg_freq;
      tbl_amp[cfg_addr]   <= cfg_amp;
      tbl_phase[cfg_addr] <= cfg_phase;
      tbl_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  // A dwell of zero behaves as one tick.
  assign tick       = (presc_q == PRESC_MAX);
  assign dwell_last = (cur_dwell_q == '0) || (dwell_cnt_q == cur_dwell_q - DWELL_W'(1));
  assign seg_end    = (state_q == S_RUN) && tick && dwell_last;
  assign is_last    = ({1'b0, seg_idx} + (AW+1)'(1)) >= cfg_len;

`ifdef AWG_SEQ_REPEAT_EN
  logic [7:0] pass_q, rep_q;
  assign more_pass = (pass_q != rep_q);
  assign pass_idx  = pass_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= '0;
      rep_q  <= '0;
    end else if (state_n != S_RUN) begin
      pass_q <= '0;
    end else if (load_en && state_q != S_RUN) begin
      pass_q <= '0;
      rep_q  <= rep_cnt;
    end else if (load_en && is_last) begin
      pass_q <= pass_q + 8'd1;
    end
  end
`else
  assign more_pass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (stop) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && cfg_len != '0) state_n = S_RUN;
        S_RUN:   if (seg_end && is_last && !loop_en && !more_pass) state_n = S_DONE;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Decide whether a segment is latched on this edge, and which one.
  always_comb begin
    load_en  = 1'b0;
    load_idx = '0;
    if (state_n == S_RUN) begin
      if (state_q != S_RUN) begin
        load_en = 1'b1;
      end else if (seg_end) begin
        load_en = 1'b1;
        if (!is_last) load_idx = seg_idx + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_n != S_RUN) begin
      state       <= WAVE_MUTE;
      state_freq  <= '0;
      state_amp   <= '0;
      state_phase <= '0;
      seg_idx     <= '0;
      cur_dwell_q <= '0;
    end else if (load_en) begin
      state       <= tbl_wave[load_idx];
      state_freq  <= tbl_freq[load_idx];
      state_amp   <= tbl_amp[load_idx];
      state_phase <= tbl_phase[load_idx];
      seg_idx     <= load_idx;
      cur_dwell_q <= tbl_dwell[load_idx];
    end
    busy <= !rst && (state_n == S_RUN);
    done <= !rst && (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || state_n != S_RUN || load_en) begin
      presc_q     <= '0;
      dwell_cnt_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// Bench for awg_seq_ctrl: directed sequences, expected output changes queued with their cycle stamps.
module tb_awg_seq_ctrl;
  localparam int DEPTH    = 8;
  localparam int DWELL_W  = 16;
  localparam int TICK_DIV = 4;
  localparam int W        = 78;
`ifdef AWG_SEQ_REPEAT_EN
  localparam logic [7:0] PI = 8'd1;
`else
  localparam logic [7:0] PI = 8'd0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_addr = '0;
  logic [4:0]         cfg_wave = '0;
  logic [11:0]        cfg_freq = '0;
  logic [7:0]         cfg_amp = '0;
  logic [7:0]         cfg_phase = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [3:0]         cfg_len = '0;
  logic               loop_en = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [4:0]         state;
  logic [11:0]        state_freq;
  logic [7:0]         state_amp, state_phase;
  logic               busy, done;
  logic [2:0]         seg_idx;
  logic [1:0]         fsm_dbg;
  logic [7:0]         pass_mon;
`ifdef AWG_SEQ_REPEAT_EN
  logic [7:0]         rep_cnt = 8'd0;
  logic [7:0]         pass_idx;
  assign pass_mon = pass_idx;
`else
  assign pass_mon = 8'd0;
`endif

  awg_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wave(cfg_wave),
    .cfg_freq(cfg_freq), .cfg_amp(cfg_amp), .cfg_phase(cfg_phase), .cfg_dwell(cfg_dwell),
    .cfg_len(cfg_len), .loop_en(loop_en), .start(start), .stop(stop),
`ifdef AWG_SEQ_REPEAT_EN
    .rep_cnt(rep_cnt), .pass_idx(pass_idx),
`endif
    .state(state), .state_freq(state_freq), .state_amp(state_amp), .state_phase(state_phase),
    .busy(busy), .seg_idx(seg_idx), .done(done), .fsm_state(fsm_dbg)
  );

  // scoreboard: {pass, wave, freq, amp, phase, busy, done, idx, cycle}
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [4:0]  sh_wave  [DEPTH];
  logic [11:0] sh_freq  [DEPTH];
  logic [7:0]  sh_amp   [DEPTH];
  logic [7:0]  sh_phase [DEPTH];

  function automatic void push_ev(input logic [7:0] p, input logic [4:0] w, input logic [11:0] f,
                                  input logic [7:0] a, input logic [7:0] ph, input logic b,
                                  input logic d, input logic [2:0] idx, input int at);
    exp_q.push_back({p, w, f, a, ph, b, d, idx, 32'(at)});
  endfunction

  function automatic void exp_seg(input int i, input logic [7:0] p, input int at);
    push_ev(p, sh_wave[i], sh_freq[i], sh_amp[i], sh_phase[i], 1'b1, 1'b0, 3'(i), at);
  endfunction

  function automatic void exp_done(input int at);
    push_ev(8'd0, 5'd10, 12'd0, 8'd0, 8'd0, 1'b0, 1'b1, 3'd0, at);
  endfunction

  function automatic void exp_mute(input int at);
    push_ev(8'd0, 5'd10, 12'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0, at);
  endfunction

  // monitor: every change of the output bundle must match the next queued event
  logic [45:0]  prev_o, cur_o;
  logic [W-1:0] e;
  always @(negedge clk) begin
    cur_o = {pass_mon, state, state_freq, state_amp, state_phase, busy, done, seg_idx};
    if (mon_en && cur_o !== prev_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: got=%h at cyc %0d, none queued", cur_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e[W-1:32] !== cur_o || e[31:0] != 32'(cyc)) begin
          bad++;
          $display("FAIL output_event: got=%h at cyc %0d, want=%h at cyc %0d",
                   cur_o, cyc, e[W-1:32], e[31:0]);
        end
      end
    end
    prev_o = cur_o;
  end

  // driver tasks
  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input int i, input logic [4:0] w, input logic [11:0] f, input logic [7:0] a,
                    input logic [7:0] ph, input logic [DWELL_W-1:0] dw);
    cfg_we = 1'b1; cfg_addr = 3'(i); cfg_wave = w; cfg_freq = f;
    cfg_amp = a; cfg_phase = ph; cfg_dwell = dw;
    sh_wave[i] = w; sh_freq[i] = f; sh_amp[i] = a; sh_phase[i] = ph;
    tk(1);
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tk(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tk(1);
    stop = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    total++;
    if (busy !== 1'b0 || fsm_dbg !== 2'd0 || state !== 5'd10) begin
      bad++;
      $display("FAIL %s: busy=%b fsm=%0d state=%0d, want busy=0 fsm=0 state=10", name, busy, fsm_dbg, state);
    end
  endtask

  int c0;
  initial begin
    tk(3);
    total++;
    if ({state, state_freq, state_amp, state_phase, busy, done, seg_idx, fsm_dbg} !==
        {5'd10, 12'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0, 2'd0}) begin
      bad++;
      $display("FAIL reset_values: state=%0d freq=%h amp=%h phase=%h busy=%b done=%b idx=%0d",
               state, state_freq, state_amp, state_phase, busy, done, seg_idx);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    tk(1);
    wr(0, 5'd0, 12'h010, 8'h20, 8'h30, 16'd2);
    wr(1, 5'd3, 12'h011, 8'h21, 8'h31, 16'd1);

    // basic: seg0 8 cycles, seg1 4 cycles, done pulse, mute
    cfg_len = 4'd2; loop_en = 1'b0;
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1); exp_seg(1, 8'd0, c0 + 9); exp_done(c0 + 13); exp_mute(c0 + 14);
    go(); wait_to(c0 + 20);
    chk_idle("idle_after_done");

    // loop with stop at cycle 20: no gap at wrap, no done
    loop_en = 1'b1;
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1); exp_seg(1, 8'd0, c0 + 9); exp_seg(0, PI, c0 + 13); exp_mute(c0 + 21);
    go(); wait_to(c0 + 20); pulse_stop(); wait_to(c0 + 30);
    loop_en = 1'b0;

    // dwell 0 lasts one tick
    wr(0, 5'd2, 12'h0AA, 8'h55, 8'h66, 16'd0);
    cfg_len = 4'd1;
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1); exp_done(c0 + 5); exp_mute(c0 + 6);
    go(); wait_to(c0 + 10);
    wr(0, 5'd0, 12'h010, 8'h20, 8'h30, 16'd2);

    // start with cfg_len=0 is ignored; start+stop together stays idle
    cfg_len = 4'd0;
    go(); tk(5);
    chk_idle("len0_start");
    cfg_len = 4'd2;
    start = 1'b1; stop = 1'b1; tk(1); start = 1'b0; stop = 1'b0; tk(5);
    chk_idle("start_stop_same");

    // live writes: seg1 takes new freq, seg0 unchanged mid-segment
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1);
    go(); wait_to(c0 + 3);
    wr(1, 5'd3, 12'h123, 8'h21, 8'h31, 16'd1);
    wr(0, 5'd0, 12'h3FF, 8'h20, 8'h30, 16'd2);
    exp_seg(1, 8'd0, c0 + 9); exp_done(c0 + 13); exp_mute(c0 + 14);
    wait_to(c0 + 20);
    wr(0, 5'd0, 12'h010, 8'h20, 8'h30, 16'd2);

    // reset mid-run, then replay from segment 0
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1); exp_mute(c0 + 6);
    go(); wait_to(c0 + 5);
    rst = 1'b1; tk(1); rst = 1'b0;
    wait_to(c0 + 15);
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1); exp_seg(1, 8'd0, c0 + 9); exp_done(c0 + 13); exp_mute(c0 + 14);
    go(); wait_to(c0 + 20);

    // full depth with wrap 7 -> 0; odd waveform codes pass through
    for (int i = 0; i < DEPTH; i++) wr(i, 5'(i), 12'(12'h100 + i), 8'(8'h40 + i), 8'(8'h80 + i), 16'd1);
    cfg_len = 4'd8; loop_en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) exp_seg(i, 8'd0, c0 + 1 + 4 * i);
    exp_seg(0, PI, c0 + 33); exp_mute(c0 + 35);
    go(); wait_to(c0 + 34); pulse_stop(); wait_to(c0 + 40);
    loop_en = 1'b0;

    // cfg_len dropping below seg_idx makes the current segment the last
    c0 = cyc;
    exp_seg(0, 8'd0, c0 + 1); exp_seg(1, 8'd0, c0 + 5); exp_seg(2, 8'd0, c0 + 9);
    exp_done(c0 + 13); exp_mute(c0 + 14);
    go(); wait_to(c0 + 10); cfg_len = 4'd2; wait_to(c0 + 20);

`ifdef AWG_SEQ_REPEAT_EN
    wr(0, 5'd0, 12'h010, 8'h20, 8'h30, 16'd2);
    wr(1, 5'd3, 12'h011, 8'h21, 8'h31, 16'd1);
    rep_cnt = 8'd2; cfg_len = 4'd2;
    c0 = cyc;
    for (int p = 0; p < 3; p++) begin
      exp_seg(0, 8'(p), c0 + 1 + 12 * p);
      exp_seg(1, 8'(p), c0 + 9 + 12 * p);
    end
    exp_done(c0 + 37); exp_mute(c0 + 38);
    go(); wait_to(c0 + 45);
    rep_cnt = 8'd0;
`endif

    tk(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got=%0d still queued, want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
